mem_seq_ctrl: RTL

- Sequences the dual-bank time memory (seconds/minutes/hours/days, alarm, chronometer fields).
- Arbitrates the single write port between two requesters: the RTC burst reader and the user-edit path.
- Issues the bank-commit flag after each completed update.
- Streams the committed bank to the display over read port 3 with a scan engine.

---
 rtl/mem_seq_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_seq_ctrl.sv
// Sequencer for the dual-bank time memory: arbitrates RTC bursts and user edits onto
// the write port, commits the write bank, and scans the committed bank out to the display.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting; serves commit, then RTC burst, then user edit, then scan
// BURST  | writing RTC bytes to addresses 0..NFIELDS-1, one per rtc_req cycle
// USR    | one-cycle single-field write (or address error)
// COMMIT | one-cycle flags=2'b10, write bank copied to read bank
// SCAN   | NFIELDS+1 cycles streaming the committed bank via read port 3
module mem_seq_ctrl #(
  parameter int unsigned NFIELDS = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rtc_req,
  input  logic [7:0] rtc_dat,
  output logic       rtc_ack,
  input  logic       usr_req,
  input  logic [3:0] usr_add,
  input  logic [7:0] usr_dat,
  output logic       usr_ack,
  output logic       usr_err,
  input  logic       tick,
  output logic [3:0] ADD1,
  output logic [7:0] DAT1,
  output logic       w1,
  output logic [1:0] flags,
  output logic [3:0] ADD3,
  input  logic [7:0] Dato3,
  output logic       scan_vld,
  output logic [3:0] scan_add,
  output logic [7:0] scan_dat,
  output logic       busy
);

  localparam logic [4:0] NF   = 5'(NFIELDS);
  localparam logic [3:0] LAST = 4'(NFIELDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BURST,
    S_USR,
    S_COMMIT,
    S_SCAN
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [4:0] cnt_q, cnt_d;
  logic       commit_pend_q, commit_pend_d;
  logic       scan_pend_q, scan_pend_d;
  logic [3:0] uadd_q, uadd_d;
  logic [7:0] udat_q, udat_d;
  logic [3:0] add3_q, add3_d;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    commit_pend_d = commit_pend_q;
    scan_pend_d   = scan_pend_q;
    uadd_d        = uadd_q;
    udat_d        = udat_q;
    add3_d        = add3_q;

    rtc_ack  = 1'b0;
    usr_ack  = 1'b0;
    usr_err  = 1'b0;
    ADD1     = 4'd0;
    DAT1     = 8'd0;
    w1       = 1'b0;
    flags    = 2'b00;
    ADD3     = add3_q;
    scan_vld = 1'b0;
    scan_add = 4'd0;
    scan_dat = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (commit_pend_q) begin
          state_d = S_COMMIT;
        end else if (rtc_req) begin
          state_d = S_BURST;
          idx_d   = 4'd0;
        end else if (usr_req) begin
          state_d = S_USR;
          uadd_d  = usr_add;
          udat_d  = usr_dat;
        end else if (scan_pend_q) begin
          // Cleared on entry so that a tick arriving mid-scan queues exactly one rescan.
          state_d     = S_SCAN;
          cnt_d       = 5'd0;
          scan_pend_d = 1'b0;
        end
      end

      S_BURST: begin
        rtc_ack = rtc_req;
        if (rtc_req) begin
          w1   = 1'b1;
          ADD1 = idx_q;
          DAT1 = rtc_dat;
          if (idx_q == LAST) begin
            commit_pend_d = 1'b1;
            state_d       = S_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_USR: begin
        usr_ack = 1'b1;
        if ({1'b0, uadd_q} < NF) begin
          w1            = 1'b1;
          ADD1          = uadd_q;
          DAT1          = udat_q;
          commit_pend_d = 1'b1;
        end else begin
          usr_err = 1'b1;
        end
        state_d = S_IDLE;
      end

      S_COMMIT: begin
        flags         = 2'b10;
        commit_pend_d = 1'b0;
        scan_pend_d   = 1'b1;
        state_d       = S_IDLE;
      end

      S_SCAN: begin
        if (cnt_q < NF) begin
          ADD3   = cnt_q[3:0];
          add3_d = cnt_q[3:0];
        end
        // Read data lags the address by one cycle, so field cnt-1 is presented.
        if (cnt_q != 5'd0) begin
          scan_vld = 1'b1;
          scan_add = cnt_q[3:0] - 4'd1;
          scan_dat = Dato3;
        end
        if (cnt_q == NF) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (tick) scan_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= 4'd0;
      cnt_q         <= 5'd0;
      commit_pend_q <= 1'b0;
      scan_pend_q   <= 1'b0;
      uadd_q        <= 4'd0;
      udat_q        <= 8'd0;
      add3_q        <= 4'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      commit_pend_q <= commit_pend_d;
      scan_pend_q   <= scan_pend_d;
      uadd_q        <= uadd_d;
      udat_q        <= udat_d;
      add3_q        <= add3_d;
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule
